fp_mult_issue_ctrl: RTL and testbench
=====================================

Name: fp_mult_issue_ctrl

Overview:
- Initiator and consumer wrapper for a fixed-latency, valid-only FP multiplier pipe (no backpressure, results emerge PIPE_LAT cycles after issue).
- Accepts operand pairs over ready/valid, issues them into the pipe and captures results in a local result FIFO.
- Presents results downstream over ready/valid.
- Credit counting guarantees the FIFO never overflows while results are in flight, so a stalled consumer (e.g. the RMSnorm accumulator) never loses a product.

Parameters:
- sig_width, 23, mantissa width; data width is DW = sig_width+exp_width+1
- exp_width, 8, exponent width
- PIPE_LAT, 5, cycles from pipe_ab_valid to pipe_z_valid; must be ≥1
- FIFO_DEPTH, 8, result FIFO entries and total credits; must be ≥2 and a power of 2; full throughput requires FIFO_DEPTH ≥ PIPE_LAT+1

Ports:
- clk, input, 1, clock, rising edge
- rst_n, input, 1, asynchronous active-low reset
- in_a, input, DW, operand A
- in_b, input, DW, operand B
- in_valid, input, 1, operand pair valid
- in_ready, output, 1, operand pair accepted when in_valid & in_ready
- pipe_a, output, DW, operand A to multiplier pipe
- pipe_b, output, DW, operand B to multiplier pipe
- pipe_ab_valid, output, 1, issue strobe to pipe
- pipe_z, input, DW, product from pipe
- pipe_z_valid, input, 1, product valid from pipe
- out_z, output, DW, head-of-FIFO product
- out_valid, output, 1, FIFO non-empty
- out_ready, input, 1, downstream accepts
- credit_cnt, output, clog2(FIFO_DEPTH)+1, free credits
- fifo_cnt, output, clog2(FIFO_DEPTH)+1, FIFO occupancy
- overflow_err, output, 1, sticky: push attempted while full with no same-cycle pop

Behaviour:
- Reset (async, rst_n=0):
  - credit_cnt=FIFO_DEPTH, fifo_cnt=0, overflow_err=0.
  - FIFO read/write pointers = 0, out_valid=0, in_ready=1 (after reset).
  - pipe_ab_valid=0. out_z value is don't-care while out_valid=0.
- Issue path:
  - in_ready = (credit_cnt != 0). It is a registered-state function only and never depends on out_ready or pipe_z_valid.
  - issue = in_valid & in_ready.
  - pipe_ab_valid = issue. pipe_a = in_a and pipe_b = in_b, combinational pass-through.
- Credit accounting: credit counts free FIFO entries minus results in flight. The invariant credit_cnt + in_flight + fifo_cnt = FIFO_DEPTH must hold at all times.
  - issue only: credit_cnt−1.
  - pop only: credit_cnt+1.
  - issue and pop in the same cycle: unchanged.
  - credit_cnt never exceeds FIFO_DEPTH or underflows.
- Result FIFO:
  - Push when pipe_z_valid=1: write pipe_z at wptr, wptr+1 with wrap modulo FIFO_DEPTH.
  - pop = out_valid & out_ready: rptr+1 with wrap.
  - out_valid = (fifo_cnt != 0). out_z = mem[rptr], first-word-fall-through from registered storage. No empty bypass: a result pushed at cycle T is visible at T+1.
  - fifo_cnt: +1 on push only, −1 on pop only, unchanged on both.
  - Push while full and pop in the same cycle is legal: no error, count stays FIFO_DEPTH.
  - Push while full with no pop: data dropped, pointers and count unchanged, overflow_err←1 (sticky until reset). Unreachable under correct credit use; kept for verification.
- Latency: operand accepted at edge T → pipe_z_valid at T+PIPE_LAT → out_valid/out_z valid from T+PIPE_LAT+1 (FIFO previously empty).
- Ordering: strictly in issue order.
- Throughput: 1 pair/cycle sustained while out_ready=1 and FIFO_DEPTH ≥ PIPE_LAT+1.
- Reset mid-operation:
  - All state returns to reset values.
  - In-flight results are discarded, relying on the pipe sharing rst_n and clearing its valids.
  - No spurious out_valid after release.

Test Plan:
- Single op: in_a=0x40000000 (2.0), in_b=0x40400000 (3.0) at cycle 0, out_ready=1 → pipe_ab_valid at cycle 0; out_valid=1 with out_z=0x40C00000 (6.0) at cycle PIPE_LAT+1=6; credit_cnt back to 8 after pop.
- Back-to-back stream, 32 pairs, out_ready=1, PIPE_LAT=5, FIFO_DEPTH=8 → in_ready stays 1, one result per cycle in order, fifo_cnt ≤ 1.
- Backpressure: out_ready=0, in_valid held → exactly 8 issues accepted, then in_ready=0. fifo_cnt reaches 8 after all in-flight results land; overflow_err=0. Raise out_ready → 8 results in order, in_ready re-asserts the cycle after the first pop.
- Simultaneous issue+pop at credit_cnt=1 → credit_cnt stays 1. With FIFO full, a push at the same cycle as a pop → fifo_cnt stays 8, no error.
- Error injection: force pipe_z_valid with FIFO full and out_ready=0 → overflow_err=1 and stays set, FIFO contents unchanged.
- Async reset asserted with 3 in flight and 4 queued → out_valid=0, fifo_cnt=0, credit_cnt=8 immediately. After release, no stale results appear within 2*PIPE_LAT cycles.

Source files
------------

// File: rtl/fp_mult_issue_ctrl.sv
// Issue/consume wrapper around a fixed-latency, valid-only FP multiplier pipe.
// Credits cover FIFO slots plus in-flight products so a stalled consumer never loses a result.
module fp_mult_issue_ctrl #(
  parameter int unsigned sig_width  = 23,
  parameter int unsigned exp_width  = 8,
  parameter int unsigned PIPE_LAT   = 5,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [sig_width+exp_width:0]  in_a,
  input  logic [sig_width+exp_width:0]  in_b,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [sig_width+exp_width:0]  pipe_a,
  output logic [sig_width+exp_width:0]  pipe_b,
  output logic                          pipe_ab_valid,
  input  logic [sig_width+exp_width:0]  pipe_z,
  input  logic                          pipe_z_valid,
  output logic [sig_width+exp_width:0]  out_z,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   credit_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          overflow_err
);

  localparam int unsigned DW = sig_width + exp_width + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  if (PIPE_LAT < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("fp_mult_issue_ctrl: PIPE_LAT must be >=1, FIFO_DEPTH a power of 2 >= 2");
  end

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          issue;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic [CW-1:0] credit_nxt;
  logic [CW-1:0] fifo_nxt;

  assign issue         = in_valid & in_ready;
  assign pipe_ab_valid = issue;
  assign pipe_a        = in_a;
  assign pipe_b        = in_b;

  assign pop     = out_valid & out_ready;
  assign full    = (fifo_cnt == DEPTH_C);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = pipe_z_valid & (~full | pop);
  assign out_z   = mem[rptr];

  always_comb begin
    credit_nxt = credit_cnt;
    if (issue && !pop) begin
      credit_nxt = credit_cnt - CW'(1);
    end else if (pop && !issue && credit_cnt != DEPTH_C) begin
      credit_nxt = credit_cnt + CW'(1);
    end
  end

  always_comb begin
    fifo_nxt = fifo_cnt;
    if (push_ok && !pop) begin
      fifo_nxt = fifo_cnt + CW'(1);
    end else if (pop && !push_ok) begin
      fifo_nxt = fifo_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt   <= DEPTH_C;
      fifo_cnt     <= '0;
      wptr         <= '0;
      rptr         <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      credit_cnt <= credit_nxt;
      fifo_cnt   <= fifo_nxt;
      in_ready   <= (credit_nxt != '0);
      out_valid  <= (fifo_nxt != '0);
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      if (pipe_z_valid && full && !pop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Storage needs no reset: out_z is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= pipe_z;
    end
  end

endmodule

// File: tb/tb_fp_mult_issue_ctrl.sv
// Bench for fp_mult_issue_ctrl: fixed-latency pipe stand-in, queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fp_mult_issue_ctrl;

  localparam int unsigned PIPE_LAT = 5;
  localparam int unsigned DEPTH    = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_a, in_b, pipe_a, pipe_b, pipe_z, out_z;
  logic        in_valid, in_ready, pipe_ab_valid, pipe_z_valid, out_valid, out_ready;
  logic [3:0]  credit_cnt, fifo_cnt;
  logic        overflow_err;
  logic        inj_valid;
  logic [31:0] inj_z;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_mult_issue_ctrl #(.sig_width(23), .exp_width(8), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_ab_valid(pipe_ab_valid),
    .pipe_z(pipe_z), .pipe_z_valid(pipe_z_valid),
    .out_z(out_z), .out_valid(out_valid), .out_ready(out_ready),
    .credit_cnt(credit_cnt), .fifo_cnt(fifo_cnt), .overflow_err(overflow_err)
  );

  // Single-precision multiply for normal operands, truncating.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (m[47]) begin
      e = e + 10'd1;
      return {a[31] ^ b[31], e[7:0], m[46:24]};
    end
    return {a[31] ^ b[31], e[7:0], m[45:23]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Multiplier pipe stand-in sharing rst_n; inj_valid forces an extra product.
  logic [PIPE_LAT-1:0] pv;
  logic [31:0]         pzr [PIPE_LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv     <= {pv[PIPE_LAT-2:0], pipe_ab_valid};
      pzr[0] <= fmul(pipe_a, pipe_b);
      for (int s = 1; s < PIPE_LAT; s++) pzr[s] <= pzr[s-1];
    end
  end
  assign pipe_z_valid = pv[PIPE_LAT-1] | inj_valid;
  assign pipe_z       = inj_valid ? inj_z : pzr[PIPE_LAT-1];

  // Reference model: products in flight with their arrival cycle, FIFO contents, credits.
  typedef struct {
    logic [31:0] z;
    int          due;
  } flight_t;
  flight_t     fq[$];
  logic [31:0] mq[$];
  int          m_credit = DEPTH;
  bit          m_err    = 1'b0;
  int          cyc      = 0;
  bit          m_rdy, m_issue, m_pop, m_push;
  logic [31:0] m_pz;

  always @(negedge clk) begin
    if (!rst_n) begin
      fq.delete();
      mq.delete();
      m_credit = DEPTH;
      m_err    = 1'b0;
    end
    m_rdy   = (m_credit != 0);
    m_issue = in_valid && m_rdy && rst_n;
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("fifo_cnt", fifo_cnt, mq.size());
    chk("credit_cnt", credit_cnt, m_credit);
    chk("overflow_err", overflow_err, m_err);
    chk("pipe_ab_valid", pipe_ab_valid, m_issue);
    if (mq.size() != 0) chk("out_z", out_z, mq[0]);
    if (m_issue) begin
      chk("pipe_a", pipe_a, in_a);
      chk("pipe_b", pipe_b, in_b);
    end
    if (rst_n) begin
      m_pop  = out_ready && (mq.size() != 0);
      m_push = 1'b0;
      m_pz   = '0;
      if (fq.size() != 0 && fq[0].due == cyc) begin
        m_push = 1'b1;
        m_pz   = fq[0].z;
        void'(fq.pop_front());
      end
      if (inj_valid) begin
        m_push = 1'b1;
        m_pz   = inj_z;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() >= DEPTH) m_err = 1'b1;
        else mq.push_back(m_pz);
      end
      if (m_issue) fq.push_back('{z: fmul(in_a, in_b), due: cyc + PIPE_LAT});
      if (m_issue && !m_pop) m_credit--;
      else if (m_pop && !m_issue && m_credit < DEPTH) m_credit++;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int maxf, stalls, acc, k;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b0; inj_valid = 1'b0; inj_z = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    chk("rst_credit", credit_cnt, 8);
    chk("rst_fifo", fifo_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overflow", overflow_err, 0);
    chk("rst_issue", pipe_ab_valid, 0);

    // Single op: 2.0 * 3.0
    tick();
    out_ready = 1'b1; in_a = 32'h40000000; in_b = 32'h40400000; in_valid = 1'b1;
    #1 chk("single_issue", pipe_ab_valid, 1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("single_not_yet", out_valid, 0);
    tick();
    chk("single_valid", out_valid, 1);
    chk("single_z", out_z, 32'h40C00000);
    chk("single_credit_busy", credit_cnt, 7);
    tick();
    chk("single_credit_back", credit_cnt, 8);
    chk("single_drained", out_valid, 0);

    // Back-to-back stream of 32 pairs
    maxf = 0; stalls = 0;
    for (int i = 0; i < 32; i++) begin
      in_a = 32'h3F800000 | (32'(i) << 18);
      in_b = 32'h40400000;
      in_valid = 1'b1;
      if (!in_ready) stalls++;
      tick();
      if (int'(fifo_cnt) > maxf) maxf = int'(fifo_cnt);
    end
    in_valid = 1'b0;
    repeat (PIPE_LAT + 2) begin
      tick();
      if (int'(fifo_cnt) > maxf) maxf = int'(fifo_cnt);
    end
    chk("stream_stalls", stalls, 0);
    chk("stream_fifo_peak", maxf, 1);

    // Backpressure: only 8 credits
    out_ready = 1'b0; acc = 0; k = 0;
    for (int c = 0; c < 12; c++) begin
      in_a = 32'h40000000 | (32'(k) << 19);
      in_b = 32'h3FC00000;
      in_valid = 1'b1;
      if (in_ready) begin acc++; k++; end
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 8);
    chk("bp_in_ready", in_ready, 0);
    repeat (2) tick();
    chk("bp_fifo_full", fifo_cnt, 8);
    chk("bp_credit", credit_cnt, 0);
    chk("bp_no_err", overflow_err, 0);

    // Full FIFO: push together with pop is legal
    inj_valid = 1'b1; inj_z = 32'hDEADBEEF; out_ready = 1'b1;
    tick();
    inj_valid = 1'b0; out_ready = 1'b0;
    chk("pushpop_fifo", fifo_cnt, 8);
    chk("pushpop_no_err", overflow_err, 0);
    chk("pushpop_in_ready", in_ready, 1);

    // Full FIFO: push without pop is dropped and flagged
    inj_valid = 1'b1; inj_z = 32'h12345678;
    tick();
    inj_valid = 1'b0;
    chk("ovf_set", overflow_err, 1);
    chk("ovf_fifo", fifo_cnt, 8);
    tick();
    chk("ovf_sticky", overflow_err, 1);
    out_ready = 1'b1;
    repeat (9) tick();
    chk("drain_fifo", fifo_cnt, 0);
    chk("drain_credit", credit_cnt, 8);
    chk("drain_sticky", overflow_err, 1);

    // Reset to clear the sticky error before the credit=1 scenario
    rst_n = 1'b0;
    #1 chk("rst2_err", overflow_err, 0);
    tick();
    rst_n = 1'b1;

    // Issue and pop together at credit_cnt=1
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_a = 32'h40800000 | (32'(i) << 20); in_b = 32'h40000000; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (PIPE_LAT + 1) tick();
    chk("c1_credit", credit_cnt, 1);
    chk("c1_fifo", fifo_cnt, 7);
    in_a = 32'h41000000; in_b = 32'h40400000; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("c1_issue_pop", credit_cnt, 1);
    out_ready = 1'b1;
    repeat (PIPE_LAT + 8) tick();
    chk("c1_drained", credit_cnt, 8);

    // Async reset with 3 in flight and 4 queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_a = 32'h3F800000 | (32'(i) << 21); in_b = 32'h40A00000; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      in_a = 32'h40400000 | (32'(i) << 21); in_b = 32'h40E00000; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_fifo", fifo_cnt, 4);
    chk("pre_rst_credit", credit_cnt, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_fifo", fifo_cnt, 0);
    chk("arst_credit", credit_cnt, 8);
    chk("arst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2 * PIPE_LAT; i++) begin
      tick();
      chk("post_rst_quiet", out_valid, 0);
    end
    chk("post_rst_fifo", fifo_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
